// File: rtl/glitch_mon_pkg.sv
// Shared types and default parameters for the glitch monitor.
// The optional min/max width tracking is controlled by GLITCH_MON_MINMAX_EN in glitch_monitor.
package glitch_mon_pkg;

    localparam int unsigned CNT_W_DEFAULT   = 32;
    localparam int unsigned TIMEOUT_DEFAULT = 12_000_000;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        DELAY,
        WIDTH,
        REPORT
    } state_e;

endpackage

// File: rtl/glitch_monitor_sync_edge.sv
// 2-FF synchronizer followed by one edge-detect register.
// Produces single-cycle rise/fall pulses.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [2:0] sh_q;
    logic [2:0] sh_d;

    always_comb begin
        sh_d = {sh_q[1:0], din};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign rise = sh_q[1] & ~sh_q[2];
    assign fall = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/glitch_monitor.sv
// Measures trigger-to-glitch delay and glitch width in clk cycles.
// Define GLITCH_MON_MINMAX_EN to add running min/max width statistics.
//
// state  | meaning
// IDLE   | waiting for arm
// ARMED  | waiting for trigger rise (armed_indicator high)
// DELAY  | counting trigger rise -> glitch rise
// WIDTH  | counting glitch rise -> glitch fall
// REPORT | result_valid high until accepted
module glitch_monitor
    import glitch_mon_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             trigger,
    input  logic             glitch_in,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [CNT_W-1:0] delay_cycles,
    output logic [CNT_W-1:0] width_cycles,
    output logic             timeout,
    output logic             armed_indicator
`ifdef GLITCH_MON_MINMAX_EN
    ,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] width_min,
    output logic [CNT_W-1:0] width_max
`endif
);

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    logic trig_rise;
    logic trig_fall;
    logic glitch_rise;
    logic glitch_fall;

    sync_edge u_sync_trig (
        .clk  (clk),
        .rst  (rst),
        .din  (trigger),
        .rise (trig_rise),
        .fall (trig_fall)
    );

    sync_edge u_sync_glitch (
        .clk  (clk),
        .rst  (rst),
        .din  (glitch_in),
        .rise (glitch_rise),
        .fall (glitch_fall)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] meas_delay_q, meas_delay_d;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic [CNT_W-1:0] width_q, width_d;
    logic             timeout_q, timeout_d;
    logic             valid_q, valid_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             width_update;

    // The counter holds cycles elapsed minus one, so the captured value is cnt_inc.
    always_comb begin
        cnt_inc      = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        state_d      = state_q;
        cnt_d        = cnt_q;
        meas_delay_d = meas_delay_q;
        delay_d      = delay_q;
        width_d      = width_q;
        timeout_d    = timeout_q;
        width_update = 1'b0;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (trig_rise) begin
                    cnt_d = '0;
                    if (glitch_rise) begin
                        meas_delay_d = '0;
                        state_d      = WIDTH;
                    end else begin
                        state_d = DELAY;
                    end
                end
            end
            DELAY: begin
                cnt_d = cnt_inc;
                if (glitch_rise) begin
                    meas_delay_d = cnt_inc;
                    cnt_d        = '0;
                    state_d      = WIDTH;
                end else if (cnt_inc == TMO) begin
                    delay_d   = TMO;
                    width_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = REPORT;
                end
            end
            WIDTH: begin
                cnt_d = cnt_inc;
                if (glitch_fall) begin
                    delay_d      = meas_delay_q;
                    width_d      = cnt_inc;
                    timeout_d    = 1'b0;
                    width_update = 1'b1;
                    state_d      = REPORT;
                end else if (cnt_inc == TMO) begin
                    delay_d   = meas_delay_q;
                    width_d   = TMO;
                    timeout_d = 1'b1;
                    state_d   = REPORT;
                end
            end
            REPORT: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = (state_d == REPORT);
        armed_d = (state_d == ARMED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            meas_delay_q <= '0;
            delay_q      <= '0;
            width_q      <= '0;
            timeout_q    <= 1'b0;
            valid_q      <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            meas_delay_q <= meas_delay_d;
            delay_q      <= delay_d;
            width_q      <= width_d;
            timeout_q    <= timeout_d;
            valid_q      <= valid_d;
            armed_q      <= armed_d;
        end
    end

    assign result_valid    = valid_q;
    assign delay_cycles    = delay_q;
    assign width_cycles    = width_q;
    assign timeout         = timeout_q;
    assign armed_indicator = armed_q;

`ifdef GLITCH_MON_MINMAX_EN
    logic [CNT_W-1:0] width_min_q, width_min_d;
    logic [CNT_W-1:0] width_max_q, width_max_d;

    always_comb begin
        width_min_d = width_min_q;
        width_max_d = width_max_q;
        if (clr_stats) begin
            width_min_d = '1;
            width_max_d = '0;
        end else if (width_update) begin
            if (width_d < width_min_q) width_min_d = width_d;
            if (width_d > width_max_q) width_max_d = width_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            width_min_q <= '1;
            width_max_q <= '0;
        end else begin
            width_min_q <= width_min_d;
            width_max_q <= width_max_d;
        end
    end

    assign width_min = width_min_q;
    assign width_max = width_max_q;
`endif

endmodule
